// File: rtl/lcd_panel_responder_pkg.sv
// Shared definitions for the LCD panel responder: opcode patterns,
// half indices, the graphic RAM geometry and the address packing helper.
package lcd_pkg;

    localparam int NUM_HALVES  = 2;
    localparam int HALF_LEFT   = 0;
    localparam int HALF_RIGHT  = 1;

    localparam int GRAM_ADDR_W = 10;
    localparam int GRAM_DEPTH  = 1 << GRAM_ADDR_W;

    // Display on/off: 0011_111d, the low bit carries the on flag
    localparam logic [7:0] DISP_MASK = 8'b1111_1110;
    localparam logic [7:0] DISP_VAL  = 8'b0011_1110;
    // Set Y (column): 01yy_yyyy
    localparam logic [1:0] SETY_VAL  = 2'b01;
    // Set X (page): 1011_1xxx
    localparam logic [4:0] SETX_VAL  = 5'b10111;
    // Display start line: 11zz_zzzz
    localparam logic [1:0] START_VAL = 2'b11;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_DISP,
        OP_SETY,
        OP_SETX,
        OP_START,
        OP_ILLEGAL
    } op_t;

    // Classify an instruction byte; the idle byte wins over any pattern match
    function automatic op_t decode_op(input logic [7:0] code, input logic [7:0] nop_code);
        op_t op;
        if (code == nop_code) begin
            op = OP_NOP;
        end else if ((code & DISP_MASK) == DISP_VAL) begin
            op = OP_DISP;
        end else if (code[7:6] == SETY_VAL) begin
            op = OP_SETY;
        end else if (code[7:3] == SETX_VAL) begin
            op = OP_SETX;
        end else if (code[7:6] == START_VAL) begin
            op = OP_START;
        end else begin
            op = OP_ILLEGAL;
        end
        return op;
    endfunction

    // Graphic RAM address layout: {half, page, col}
    function automatic logic [GRAM_ADDR_W-1:0] pack_addr(
        input logic       half,
        input logic [2:0] page,
        input logic [5:0] col
    );
        return {half, page, col};
    endfunction

endpackage

// File: rtl/lcd_panel_responder_if.sv
// Two-chip graphic LCD bus as seen between the driver and the responder.
interface lcd_panel_responder_if;

    logic [7:0] db_i;    // data / instruction byte
    logic       dori_i;  // 1 = data, 0 = instruction
    logic [1:0] cs_i;    // [0] left half, [1] right half
    logic       en_i;    // enable strobe, falling edge latches
    logic       rw_i;    // 1 = read, 0 = write
    logic       rst_i;   // panel reset, active-high

    modport master (
        output db_i, dori_i, cs_i, en_i, rw_i, rst_i
    );

    modport slave (
        input db_i, dori_i, cs_i, en_i, rw_i, rst_i
    );

endinterface

// File: rtl/lcd_panel_responder_gram.sv
// 1024x8 simple dual-port graphic RAM: one write port, one registered
// read port. A same-address read and write in one cycle returns old data.
module lcd_gram
    import lcd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [GRAM_ADDR_W-1:0] wr_addr,
    input  logic [7:0]             wr_data,
    input  logic [GRAM_ADDR_W-1:0] rd_addr,
    output logic [7:0]             rd_data
);

    logic [7:0] mem [GRAM_DEPTH];
    logic [7:0] rd_data_reg;

    // Write port; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, sees the array before this edge's write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/lcd_panel_responder.sv
// Far-side responder for the two-chip 128x64 graphic LCD bus. Decodes
// instructions and data writes per half, tracks page/column/start-line
// and display state, and mirrors written pixels into a graphic RAM.
module lcd_panel_responder
    import lcd_pkg::*;
#(
    parameter logic [7:0] NOP_CODE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rstn,
    lcd_panel_responder_if.slave   bus,
    input  logic [GRAM_ADDR_W-1:0] rd_addr_i,
    output logic [7:0]             rd_data_o,
    output logic [1:0]             display_on_o,
    output logic [11:0]            start_line_o,
    output logic [5:0]             page_o,
    output logic [11:0]            col_o,
    output logic                   frame_done_o,
    output logic                   illegal_o
);

    // Bus values delayed by one cycle; the driver moves the bus on the
    // same edge that en falls, so transactions use these copies.
    logic [7:0] db_q;
    logic       dori_q;
    logic [1:0] cs_q;
    logic       en_q;
    logic       rw_q;
    logic       rst_q;

    logic       event_fire;
    logic       commit;
    logic       instr_commit;
    logic       data_commit;
    op_t        op;

    logic [NUM_HALVES-1:0][GRAM_ADDR_W-1:0] half_addr;

    // Right-half write deferred by one edge when both halves take data
    logic                   pend_valid_reg;
    logic [GRAM_ADDR_W-1:0] pend_addr_reg;
    logic [7:0]             pend_data_reg;

    logic                   wr_en;
    logic [GRAM_ADDR_W-1:0] wr_addr;
    logic [7:0]             wr_data;

    logic                   frame_done_reg;
    logic                   illegal_reg;

    // Sample the LCD bus every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_q   <= '0;
            dori_q <= 1'b0;
            cs_q   <= '0;
            en_q   <= 1'b0;
            rw_q   <= 1'b0;
            rst_q  <= 1'b0;
        end else begin
            db_q   <= bus.db_i;
            dori_q <= bus.dori_i;
            cs_q   <= bus.cs_i;
            en_q   <= bus.en_i;
            rw_q   <= bus.rw_i;
            rst_q  <= bus.rst_i;
        end
    end

    // Falling edge of en; reads, panel reset and no chip select drop it
    assign event_fire   = en_q & ~bus.en_i;
    assign commit       = event_fire & ~rst_q & ~rw_q & (|cs_q);
    assign instr_commit = commit & ~dori_q;
    assign data_commit  = commit & dori_q;
    assign op           = decode_op(db_q, NOP_CODE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HALVES; gi++) begin : gen_half
            logic       disp_reg;
            logic [5:0] start_reg;
            logic [2:0] page_reg;
            logic [5:0] col_reg;

            // Per-half display state and X/Y counters
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    disp_reg  <= 1'b0;
                    start_reg <= '0;
                    page_reg  <= '0;
                    col_reg   <= '0;
                end else if (rst_q) begin
                    disp_reg  <= 1'b0;
                    start_reg <= '0;
                    page_reg  <= '0;
                    col_reg   <= '0;
                end else if (commit && cs_q[gi]) begin
                    if (dori_q) begin
                        // Column auto-increments and wraps 63 -> 0
                        col_reg <= col_reg + 6'd1;
                    end else begin
                        case (op)
                            OP_DISP:  disp_reg  <= db_q[0];
                            OP_SETY:  col_reg   <= db_q[5:0];
                            OP_SETX:  page_reg  <= db_q[2:0];
                            OP_START: start_reg <= db_q[5:0];
                            default:  ;
                        endcase
                    end
                end
            end

            assign display_on_o[gi]          = disp_reg;
            assign start_line_o[gi*6 +: 6]   = start_reg;
            assign page_o[gi*3 +: 3]         = page_reg;
            assign col_o[gi*6 +: 6]          = col_reg;
            assign half_addr[gi]             = pack_addr(1'(gi), page_reg, col_reg);
        end
    endgenerate

    // Queue the right-half write when both halves are selected
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
        end else begin
            pend_valid_reg <= data_commit && (cs_q == 2'b11);
            if (data_commit && (cs_q == 2'b11)) begin
                pend_addr_reg <= half_addr[HALF_RIGHT];
                pend_data_reg <= db_q;
            end
        end
    end

    // Single RAM write port: deferred right write first, else the event's half
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = half_addr[HALF_LEFT];
        wr_data = db_q;
        if (pend_valid_reg) begin
            wr_en   = ~rst_q;
            wr_addr = pend_addr_reg;
            wr_data = pend_data_reg;
        end else if (data_commit) begin
            wr_en = 1'b1;
            if (!cs_q[HALF_LEFT]) begin
                wr_addr = half_addr[HALF_RIGHT];
            end
        end
    end

    // Frame pulse on display-on commit, sticky flag on undecodable bytes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_done_reg <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            frame_done_reg <= instr_commit && (op == OP_DISP) && db_q[0];
            if (instr_commit && (op == OP_ILLEGAL)) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    assign frame_done_o = frame_done_reg;
    assign illegal_o    = illegal_reg;

    lcd_gram u_gram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_i),
        .rd_data (rd_data_o)
    );

endmodule
